// File: rtl/example_6_1_3_pkg.sv
// example_6_1_3_pkg: state encoding and defaults for the mod-4 pulse counter
package example_6_1_3_pkg;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} state_t;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/example_6_1_3_if.sv
// example_6_1_3_if: pulse input plus exported state, next state and wrap output
interface example_6_1_3_if;
  logic x;
  logic y2;
  logic y1;
  logic ny2;
  logic ny1;
  logic z;
  modport master (output x, input y2, y1, ny2, ny1, z);
  modport slave (input x, output y2, y1, ny2, ny1, z);
endinterface

// File: rtl/example_6_1_3_pulse_sync_edge.sv
// example_6_1_3_pulse_sync_edge: synchronizes async x and emits a one-cycle rising-edge event
module example_6_1_3_pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rd,
  input  logic i_x,
  output logic o_evt
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_x_d;
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      r_sync <= '0;
      r_x_d <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_x};
      r_x_d <= r_sync[SYNC_STAGES-1];
    end
  end
  assign o_evt = r_sync[SYNC_STAGES-1] & ~r_x_d;
endmodule

// File: rtl/example_6_1_3.sv
// example_6_1_3: counts synchronized x pulses modulo 4, pulsing z on the S3->S0 wrap
module example_6_1_3
  import example_6_1_3_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic clk,
  input logic rd,
  example_6_1_3_if.slave bus
);
  state_t r_state;
  state_t w_next;
  logic w_evt;
  logic w_z;
  example_6_1_3_pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rd(rd),
    .i_x(bus.x),
    .o_evt(w_evt)
  );
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) r_state <= S0;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = w_evt ? state_t'(r_state + 2'd1) : r_state;
    w_z = w_evt && (r_state == S3);
  end
  assign bus.y2 = r_state[1];
  assign bus.y1 = r_state[0];
  assign bus.ny2 = w_next[1];
  assign bus.ny1 = w_next[0];
  assign bus.z = w_z;
endmodule

// File: tb/tb_example_6_1_3.sv
// tb_example_6_1_3: scenario and random pulse tests against a rising-edge counting model
module tb_example_6_1_3;
  logic clk = 1'b0;
  logic rd = 1'b0;
  int vectors = 0;
  int errors = 0;
  bit hist[$];
  example_6_1_3_if bus();
  example_6_1_3 #(.SYNC_STAGES(2)) dut (.clk(clk), .rd(rd), .bus(bus.slave));
  always #5 clk = ~clk;
  // every edge taken out of reset records the level of x that the first sync flop captured
  always @(posedge clk) if (rd) hist.push_back(bus.x);
  always @(negedge rd) hist.delete();
  // state after edge k = rising edges of the sampled x seen two edges earlier, mod 4
  function automatic logic [4:0] model();
    int k = hist.size();
    int rises = 0;
    bit e;
    logic [1:0] st, nx;
    for (int j = 0; j < k - 2; j++) if (hist[j] && (j == 0 || !hist[j-1])) rises++;
    e = (k >= 2) && hist[k-2] && (k < 3 || !hist[k-3]);
    st = 2'(rises % 4);
    nx = 2'((rises + int'(e)) % 4);
    return {st, nx, e && st == 2'b11};
  endfunction
  function automatic logic [4:0] observed();
    return {bus.y2, bus.y1, bus.ny2, bus.ny1, bus.z};
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rd = 1'b0;
    bus.x = 1'b0;
    repeat (3) @(negedge clk);
    rd = 1'b1;
  endtask
  task automatic test_reset();
    logic [4:0] got, exp;
    bus.x = 1'b0;
    rd = 1'b0;
    repeat (5) begin
      @(negedge clk);
      got = observed();
      vectors++;
      if (got !== 5'b0) begin errors++; $display("FAIL reset_hold got=%b exp=%b", got, 5'b0); end
    end
    rd = 1'b1;
    repeat (100) begin
      @(negedge clk);
      got = observed();
      exp = model();
      vectors++;
      if (got !== exp || got !== 5'b0) begin errors++; $display("FAIL reset_idle t=%0t got=%b exp=%b", $time, got, exp); end
    end
  endtask
  task automatic test_single();
    logic [4:0] got, exp;
    int chg = 0, zs = 0;
    int lv[2] = '{1, 0};
    int ln[2] = '{5, 20};
    for (int i = 0; i < 2; i++) begin
      bus.x = lv[i][0];
      repeat (ln[i]) begin
        @(negedge clk);
        got = observed();
        exp = model();
        vectors++;
        if (got !== exp) begin errors++; $display("FAIL single t=%0t got=%b exp=%b", $time, got, exp); end
        if (got[4:3] != got[2:1]) chg++;
        if (got[0]) zs++;
      end
    end
    vectors++;
    if (chg != 1 || zs != 0 || got[4:3] !== 2'b01) begin
      errors++; $display("FAIL single_summary changes=%0d z=%0d state=%b exp changes=1 z=0 state=01", chg, zs, got[4:3]);
    end
  endtask
  task automatic test_four();
    logic [4:0] got, exp;
    logic [1:0] seq[$];
    int zs = 0;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int h = 1; h >= 0; h--) begin
        bus.x = h[0];
        repeat (h ? 5 : 20) begin
          @(negedge clk);
          got = observed();
          exp = model();
          vectors++;
          if (got !== exp) begin errors++; $display("FAIL four t=%0t got=%b exp=%b", $time, got, exp); end
          if (got[0]) begin
            zs++;
            vectors++;
            if (got[4:1] !== 4'b1100) begin errors++; $display("FAIL four_zwrap y/ny=%b exp=1100", got[4:1]); end
          end
          if (got[4:3] != got[2:1]) seq.push_back(got[2:1]);
        end
      end
    end
    vectors++;
    if (zs != 1 || seq.size() != 4 || seq[0] != 2'b01 || seq[1] != 2'b10 || seq[2] != 2'b11 || seq[3] != 2'b00) begin
      errors++; $display("FAIL four_seq z_cycles=%0d transitions=%0d exp z_cycles=1 seq 01,10,11,00", zs, seq.size());
    end
  endtask
  task automatic test_long();
    logic [4:0] got, exp;
    logic [1:0] start;
    int chg = 0;
    start = {bus.y2, bus.y1};
    for (int h = 1; h >= 0; h--) begin
      bus.x = h[0];
      repeat (h ? 50 : 10) begin
        @(negedge clk);
        got = observed();
        exp = model();
        vectors++;
        if (got !== exp) begin errors++; $display("FAIL long t=%0t got=%b exp=%b", $time, got, exp); end
        if (got[4:3] != got[2:1]) chg++;
      end
    end
    vectors++;
    if (chg != 1 || got[4:3] !== start + 2'd1) begin
      errors++; $display("FAIL long_summary changes=%0d state=%b exp changes=1 state=%b", chg, got[4:3], start + 2'd1);
    end
  endtask
  task automatic test_mid_reset();
    logic [4:0] got, exp;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      bus.x = 1'b1;
      repeat (5) @(negedge clk);
      bus.x = 1'b0;
      repeat (10) @(negedge clk);
    end
    got = observed();
    exp = model();
    vectors++;
    if (got !== exp || got[4:3] !== 2'b10) begin errors++; $display("FAIL midreset_s2 got=%b exp=%b", got, exp); end
    bus.x = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rd = 1'b0;
    #1 got = observed();
    vectors++;
    if (got !== 5'b0) begin errors++; $display("FAIL midreset_async got=%b exp=00000", got); end
    @(negedge clk);
    bus.x = 1'b0;
    rd = 1'b1;
    for (int h = 1; h >= 0; h--) begin
      bus.x = h[0];
      repeat (h ? 5 : 10) begin
        @(negedge clk);
        got = observed();
        exp = model();
        vectors++;
        if (got !== exp) begin errors++; $display("FAIL midreset_after t=%0t got=%b exp=%b", $time, got, exp); end
      end
    end
    vectors++;
    if (got[4:3] !== 2'b01) begin errors++; $display("FAIL midreset_next state=%b exp=01", got[4:3]); end
  endtask
  task automatic test_release_high();
    logic [4:0] got, exp;
    int chg = 0;
    int lv[4] = '{1, 0, 1, 0};
    int ln[4] = '{20, 10, 10, 10};
    @(negedge clk);
    rd = 1'b0;
    bus.x = 1'b1;
    repeat (3) @(negedge clk);
    rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.x = lv[i][0];
      repeat (ln[i]) begin
        @(negedge clk);
        got = observed();
        exp = model();
        vectors++;
        if (got !== exp) begin errors++; $display("FAIL release_high t=%0t got=%b exp=%b", $time, got, exp); end
        if (got[4:3] != got[2:1]) chg++;
      end
      if (i == 0) begin
        vectors++;
        if (chg != 1 || got[4:3] !== 2'b01) begin errors++; $display("FAIL release_once changes=%0d state=%b exp 1/01", chg, got[4:3]); end
      end
    end
    vectors++;
    if (chg != 2 || got[4:3] !== 2'b10) begin errors++; $display("FAIL release_repulse changes=%0d state=%b exp 2/10", chg, got[4:3]); end
  endtask
  task automatic test_random();
    logic [4:0] got, exp;
    do_reset();
    repeat (40) begin
      for (int h = 1; h >= 0; h--) begin
        bus.x = h[0];
        repeat ($urandom_range(h ? 8 : 10, 3)) begin
          @(negedge clk);
          got = observed();
          exp = model();
          vectors++;
          if (got !== exp) begin errors++; $display("FAIL random t=%0t got=%b exp=%b", $time, got, exp); end
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_four();
    test_long();
    test_mid_reset();
    test_release_high();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
